// File: rtl/fpu_resp_collector_if.sv
// rtl/fpu_resp_collector_if.sv - issue, FPU result and response handshake bundle for fpu_resp_collector (resp_cycle present only with FPU_RESP_TIMESTAMP_EN)
interface fpu_resp_collector_if;
    // Issue side, as driven into the FPU
    logic        issue_valid;
    logic [31:0] issue_opa;
    logic [31:0] issue_opb;
    logic [2:0]  issue_op;
    logic [1:0]  issue_rmode;

    // FPU result side
    logic [31:0] fpu_out;
    logic [7:0]  fpu_flags;

    // Response side towards the checker
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_opa;
    logic [31:0] resp_opb;
    logic [2:0]  resp_op;
    logic [1:0]  resp_rmode;
    logic [31:0] resp_out;
    logic [7:0]  resp_flags;
    logic [7:0]  resp_tag;
`ifdef FPU_RESP_TIMESTAMP_EN
    logic [31:0] resp_cycle;
`endif

    modport master (
        output issue_valid, issue_opa, issue_opb, issue_op, issue_rmode,
        output fpu_out, fpu_flags, resp_ready,
`ifdef FPU_RESP_TIMESTAMP_EN
        input  resp_cycle,
`endif
        input  resp_valid, resp_opa, resp_opb, resp_op, resp_rmode,
        input  resp_out, resp_flags, resp_tag
    );

    modport slave (
        input  issue_valid, issue_opa, issue_opb, issue_op, issue_rmode,
        input  fpu_out, fpu_flags, resp_ready,
`ifdef FPU_RESP_TIMESTAMP_EN
        output resp_cycle,
`endif
        output resp_valid, resp_opa, resp_opb, resp_op, resp_rmode,
        output resp_out, resp_flags, resp_tag
    );
endinterface

// File: rtl/fpu_resp_collector.sv
// rtl/fpu_resp_collector.sv - FPU response collector: latency-matched issue pipeline, result capture, FWFT response FIFO (FPU_RESP_TIMESTAMP_EN adds resp_cycle)
module fpu_resp_collector #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    fpu_resp_collector_if.slave  bus,
    output logic [4:0]           inflight,
    output logic                 drop_err,
    output logic [7:0]           drop_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] opa;
        logic [31:0] opb;
        logic [2:0]  op;
        logic [1:0]  rmode;
        logic [7:0]  tag;
`ifdef FPU_RESP_TIMESTAMP_EN
        logic [31:0] cycle;
`endif
    } issue_t;

    typedef struct packed {
        issue_t      iss;
        logic [31:0] out;
        logic [7:0]  flags;
    } txn_t;

    issue_t             issue_word;
    issue_t             pipe_q [LATENCY];
    issue_t             pipe_d [LATENCY];
    logic [LATENCY-1:0] pvld_q;
    logic [LATENCY-1:0] pvld_d;
    logic [7:0]         tag_q;
    logic [7:0]         tag_d;

    txn_t               cap_q;
    txn_t               cap_d;
    logic               cap_vld_q;
    logic               cap_vld_d;

    txn_t               mem_q [DEPTH];
    txn_t               mem_d [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW-1:0]      rd_ptr_d;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;

    logic               drop_err_q;
    logic               drop_err_d;
    logic [7:0]         drop_count_q;
    logic [7:0]         drop_count_d;

    logic               fifo_full;
    logic               fifo_nonempty;
    logic               pop;
    logic               push;
    logic               drop;
    txn_t               head;

`ifdef FPU_RESP_TIMESTAMP_EN
    logic [31:0]        cyc_q;
    logic [31:0]        cyc_d;

    // Free-running cycle counter used to stamp each issue
    always_comb begin
        cyc_d = cyc_q + 32'd1;
    end

    // Timestamp counter register, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end
`endif

    // Assemble the payload sampled on an issue, tagged with the running sequence number
    always_comb begin
        issue_word       = '0;
        issue_word.opa   = bus.issue_opa;
        issue_word.opb   = bus.issue_opb;
        issue_word.op    = bus.issue_op;
        issue_word.rmode = bus.issue_rmode;
        issue_word.tag   = tag_q;
`ifdef FPU_RESP_TIMESTAMP_EN
        issue_word.cycle = cyc_q;
`endif
    end

    // Advance the delay pipeline one stage per cycle so the last stage lines up with the FPU output
    always_comb begin
        pvld_d    = '0;
        pipe_d    = pipe_q;
        pvld_d[0] = bus.issue_valid;
        pipe_d[0] = bus.issue_valid ? issue_word : pipe_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            pvld_d[i] = pvld_q[i-1];
            pipe_d[i] = pipe_q[i-1];
        end
        tag_d = bus.issue_valid ? tag_q + 8'd1 : tag_q;
    end

    // Pair the emerging payload with this cycle's FPU result and flags
    always_comb begin
        cap_vld_d = pvld_q[LATENCY-1];
        cap_d     = cap_q;
        if (pvld_q[LATENCY-1]) begin
            cap_d.iss   = pipe_q[LATENCY-1];
            cap_d.out   = bus.fpu_out;
            cap_d.flags = bus.fpu_flags;
        end
    end

    // Response FIFO bookkeeping; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        fifo_nonempty = (count_q != '0);
        fifo_full     = (count_q == CW'(DEPTH));
        pop           = fifo_nonempty && bus.resp_ready;
        push          = cap_vld_q && (!fifo_full || pop);
        drop          = cap_vld_q && fifo_full && !pop;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = cap_q;
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        drop_err_d   = drop_err_q | drop;
        drop_count_d = (drop && (drop_count_q != 8'hFF)) ? drop_count_q + 8'd1 : drop_count_q;
    end

    // Control state: valid bits, tag, pointers and drop tracking, all cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pvld_q       <= '0;
            tag_q        <= '0;
            cap_vld_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_err_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            pvld_q       <= pvld_d;
            tag_q        <= tag_d;
            cap_vld_q    <= cap_vld_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_err_q   <= drop_err_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Payload storage; only meaningful where the matching valid bit or FIFO count says so
    always_ff @(posedge clk) begin
        pipe_q <= pipe_d;
        cap_q  <= cap_d;
        mem_q  <= mem_d;
    end

    // Present the FIFO head, forced to zero while empty so idle outputs read as 0
    always_comb begin
        head = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
    end

    // Number of occupied pipeline stages
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + 5'(pvld_q[i]);
        end
    end

    assign bus.resp_valid = fifo_nonempty;
    assign bus.resp_opa   = head.iss.opa;
    assign bus.resp_opb   = head.iss.opb;
    assign bus.resp_op    = head.iss.op;
    assign bus.resp_rmode = head.iss.rmode;
    assign bus.resp_tag   = head.iss.tag;
    assign bus.resp_out   = head.out;
    assign bus.resp_flags = head.flags;
`ifdef FPU_RESP_TIMESTAMP_EN
    assign bus.resp_cycle = head.iss.cycle;
`endif
    assign drop_err       = drop_err_q;
    assign drop_count     = drop_count_q;
endmodule

// File: tb/tb_fpu_resp_collector.sv
// tb/tb_fpu_resp_collector.sv - randomized self-checking bench for fpu_resp_collector against a transaction-level model
module tb_fpu_resp_collector;
    localparam int LAT = 4;
    localparam int DEP = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] inflight;
    logic       drop_err;
    logic [7:0] drop_count;

    fpu_resp_collector_if bus();

    fpu_resp_collector #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .inflight   (inflight),
        .drop_err   (drop_err),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [2:0]  op;
        logic [1:0]  rmode;
        logic [7:0]  tag;
        logic [31:0] out;
        logic [7:0]  flags;
    } tb_txn_t;

    typedef struct {
        int         e;
        logic [7:0] tag;
    } obs_t;

    tb_txn_t    pend_m[$];
    tb_txn_t    comp_m[$];
    tb_txn_t    fifo_m[$];
    logic [7:0] tag_m;
    logic       derr_m;
    int         dcnt_m;
    int         edge_n;
    obs_t       obs[$];
    bit         auto_fpu;

    int n_tests;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    task automatic set_issue(input bit v);
        bus.issue_valid = v;
        bus.issue_opa   = $urandom;
        bus.issue_opb   = $urandom;
        bus.issue_op    = 3'($urandom_range(0, 7));
        bus.issue_rmode = 2'($urandom_range(0, 3));
    endtask

    // Transaction-level reference: issues become due LAT edges later, enter the FIFO one edge after that
    task automatic model_edge();
        tb_txn_t t;
        bit      p;
        int      sz;
        if (reset) begin
            pend_m.delete();
            comp_m.delete();
            fifo_m.delete();
            tag_m  = 8'd0;
            derr_m = 1'b0;
            dcnt_m = 0;
        end else begin
            sz = fifo_m.size();
            p  = (sz > 0) && bus.resp_ready;
            if (p) void'(fifo_m.pop_front());
            if (comp_m.size() > 0 && comp_m[0].due + 1 == edge_n) begin
                t = comp_m.pop_front();
                if (sz < DEP || p) fifo_m.push_back(t);
                else begin
                    derr_m = 1'b1;
                    if (dcnt_m < 255) dcnt_m++;
                end
            end
            if (pend_m.size() > 0 && pend_m[0].due == edge_n) begin
                t       = pend_m.pop_front();
                t.out   = bus.fpu_out;
                t.flags = bus.fpu_flags;
                comp_m.push_back(t);
            end
            if (bus.issue_valid) begin
                t.due   = edge_n + LAT;
                t.opa   = bus.issue_opa;
                t.opb   = bus.issue_opb;
                t.op    = bus.issue_op;
                t.rmode = bus.issue_rmode;
                t.tag   = tag_m;
                t.out   = '0;
                t.flags = '0;
                tag_m   = tag_m + 8'd1;
                pend_m.push_back(t);
            end
        end
        edge_n++;
    endtask

    task automatic cycle();
        tb_txn_t h;
        bit      ev;
        if (auto_fpu) begin
            bus.fpu_out   = $urandom;
            bus.fpu_flags = 8'($urandom);
        end
        if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) obs.push_back('{edge_n, bus.resp_tag});
        @(posedge clk);
        model_edge();
        @(negedge clk);
        ev = fifo_m.size() > 0;
        h  = '{default: '0};
        if (ev) h = fifo_m[0];
        chk("resp_valid", bus.resp_valid, ev);
        chk("resp_opa", bus.resp_opa, h.opa);
        chk("resp_opb", bus.resp_opb, h.opb);
        chk("resp_op", bus.resp_op, h.op);
        chk("resp_rmode", bus.resp_rmode, h.rmode);
        chk("resp_out", bus.resp_out, h.out);
        chk("resp_flags", bus.resp_flags, h.flags);
        chk("resp_tag", bus.resp_tag, h.tag);
        chk("inflight", inflight, pend_m.size());
        chk("drop_err", drop_err, derr_m);
        chk("drop_count", drop_count, dcnt_m);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_issue(1'b1);
        cycle();
        chk("rst_valid", bus.resp_valid, 0);
        chk("rst_opa", bus.resp_opa, 0);
        chk("rst_out", bus.resp_out, 0);
        chk("rst_tag", bus.resp_tag, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_drop_err", drop_err, 0);
        chk("rst_drop_count", drop_count, 0);
        reset = 1'b0;
        set_issue(1'b0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        edge_n   = 0;
        tag_m    = 8'd0;
        derr_m   = 1'b0;
        dcnt_m   = 0;
        auto_fpu = 1'b1;
        reset    = 1'b1;
        bus.resp_ready = 1'b0;
        bus.fpu_out    = '0;
        bus.fpu_flags  = '0;
        set_issue(1'b0);
        repeat (2) cycle();
        do_reset();

        // Single op with a known result at exactly the capture edge
        auto_fpu = 1'b0;
        bus.resp_ready  = 1'b0;
        bus.issue_valid = 1'b1;
        bus.issue_opa   = 32'h3F800000;
        bus.issue_opb   = 32'h40000000;
        bus.issue_op    = 3'b000;
        bus.issue_rmode = 2'b00;
        bus.fpu_out     = 32'h0BAD0000;
        bus.fpu_flags   = 8'h5A;
        cycle();
        set_issue(1'b0);
        for (int k = 1; k <= LAT + 1; k++) begin
            bus.fpu_out   = (k == LAT) ? 32'h40400000 : (32'h0BAD0000 | k);
            bus.fpu_flags = (k == LAT) ? 8'h00 : 8'h5A;
            cycle();
            chk("single_valid_timing", bus.resp_valid, (k == LAT + 1));
        end
        chk("single_tag", bus.resp_tag, 0);
        chk("single_out", bus.resp_out, 32'h40400000);
        chk("single_flags", bus.resp_flags, 0);
        chk("single_opa", bus.resp_opa, 32'h3F800000);
        chk("single_opb", bus.resp_opb, 32'h40000000);
        auto_fpu = 1'b1;
        bus.resp_ready = 1'b1;
        repeat (3) cycle();

        // Back-to-back with the consumer always ready
        do_reset();
        bus.resp_ready = 1'b1;
        obs.delete();
        for (int i = 0; i < 20; i++) begin
            set_issue(1'b1);
            cycle();
            if (i == 10) chk("b2b_inflight", inflight, LAT);
        end
        set_issue(1'b0);
        repeat (10) cycle();
        chk("b2b_count", obs.size(), 20);
        for (int i = 0; i < obs.size() && i < 20; i++) begin
            chk("b2b_tag", obs[i].tag, i);
            chk("b2b_consecutive", obs[i].e - obs[0].e, i);
        end

        // Backpressure and overflow
        do_reset();
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_issue(1'b1);
            cycle();
        end
        set_issue(1'b0);
        repeat (6) cycle();
        chk("ovf_drop_count", drop_count, 2);
        chk("ovf_drop_err", drop_err, 1);
        chk("ovf_valid", bus.resp_valid, 1);
        obs.delete();
        bus.resp_ready = 1'b1;
        repeat (10) cycle();
        chk("ovf_drain_count", obs.size(), 8);
        for (int i = 0; i < obs.size() && i < 8; i++) chk("ovf_tag", obs[i].tag, i);

        // Full FIFO with a pop in the same cycle as the incoming push
        do_reset();
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_issue(1'b1);
            cycle();
        end
        set_issue(1'b0);
        for (int j = 1; j <= 8; j++) begin
            bus.resp_ready = (j == 5);
            cycle();
        end
        chk("fullpop_drop_count", drop_count, 0);
        chk("fullpop_drop_err", drop_err, 0);
        obs.delete();
        bus.resp_ready = 1'b1;
        repeat (10) cycle();
        chk("fullpop_entries", obs.size(), 8);
        for (int i = 0; i < obs.size() && i < 8; i++) chk("fullpop_tag", obs[i].tag, i + 1);

        // Tag wrap
        do_reset();
        bus.resp_ready = 1'b1;
        obs.delete();
        for (int i = 0; i < 257; i++) begin
            set_issue(1'b1);
            cycle();
        end
        set_issue(1'b0);
        repeat (8) cycle();
        chk("wrap_count", obs.size(), 257);
        if (obs.size() >= 257) begin
            chk("wrap_tag255", obs[255].tag, 255);
            chk("wrap_tag0", obs[256].tag, 0);
        end

        // Reset with operations in flight
        do_reset();
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_issue(1'b1);
            cycle();
        end
        do_reset();
        obs.delete();
        repeat (8) cycle();
        chk("midrst_no_resp", obs.size(), 0);
        set_issue(1'b1);
        cycle();
        set_issue(1'b0);
        repeat (8) cycle();
        chk("midrst_resp_count", obs.size(), 1);
        if (obs.size() >= 1) chk("midrst_tag", obs[0].tag, 0);

        // Randomized traffic with alternating light and heavy backpressure
        do_reset();
        for (int i = 0; i < 800; i++) begin
            set_issue($urandom_range(0, 9) < 7);
            if (((i / 100) % 2) == 1) bus.resp_ready = ($urandom_range(0, 9) < 8);
            else                      bus.resp_ready = ($urandom_range(0, 9) < 3);
            cycle();
        end
        set_issue(1'b0);
        bus.resp_ready = 1'b1;
        repeat (20) cycle();
        chk("rand_drained", bus.resp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_resp_collector.md
# fpu_resp_collector

Response-side collector for the FPU verification environment, the receiving end of the operation stream the stimulus generator drives into the FPU. It tracks every issued operation through a delay pipeline that matches the FPU's fixed latency, pairs it with the FPU result and exception flags, tags it with a sequence number, and buffers the completed transaction for the checker over a valid/ready handshake. It sits between the FPU outputs and the checker/scoreboard in the test top.

## Interface
- LATENCY, 4: cycles from an issue-port sample to the matching valid FPU output (legal range 1..16).
- DEPTH, 8: response FIFO entries (power of two, 2..64).

- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- issue_valid  input  1  an operation is presented to the FPU this cycle.
- issue_opa / issue_opb  input  32  operands as driven to the FPU.
- issue_op  input  3  FPU opcode.
- issue_rmode  input  2  rounding mode.
- fpu_out  input  32  FPU result.
- fpu_flags  input  8  {inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero}, MSB first.
- resp_valid  output  1  FIFO head holds a transaction.
- resp_ready  input  1  consumer accepts the head.
- resp_opa / resp_opb  output  32  operands of the head transaction.
- resp_op  output  3, resp_rmode  output  2  opcode and rounding mode of the head transaction.
- resp_out  output  32, resp_flags  output  8  captured FPU result and flags.
- resp_tag  output  8  issue sequence number.
- inflight  output  5  number of valid pipeline stages.
- drop_err  output  1  sticky: a completed transaction was lost.
- drop_count  output  8  saturating count of lost transactions.

## Operation
- The issue stage samples {opa, opb, op, rmode, tag} when issue_valid=1 and pushes it into a LATENCY-deep shift pipeline that carries a per-stage valid bit.
- The tag counter starts at 0, increments once per sampled issue, and wraps from 255 to 0.
- When the last pipeline stage is valid, that cycle's fpu_out and fpu_flags are captured together with the stage payload as one transaction, which is then pushed into the FIFO.
- The FIFO is first-word-fall-through. A pop occurs when resp_valid && resp_ready.
- If the FIFO is full with no pop in the same cycle, the transaction is discarded. drop_err is set and drop_count increments, saturating at 255.
- If the FIFO is full and a pop occurs in the same cycle, the push is accepted and the entry count is unchanged.
- inflight is the popcount of the pipeline valid bits. It includes a stage that is entering and leaving in the same cycle.
- While resp_valid=1 and resp_ready=0, all resp_* outputs hold stable.
- Reset clears the following: pipeline valid bits, FIFO pointers, tag, drop_err and drop_count. Operations in flight at reset are discarded and never produce a response.

## Timing
- Output values on reset: resp_valid=0, all resp_* data=0, inflight=0, drop_err=0, drop_count=0.
- An issue sampled at edge N is paired with fpu_out sampled at edge N+LATENCY.
- resp_valid rises one cycle after that capture edge, provided the FIFO was empty.
- Minimum issue-to-resp_valid latency is LATENCY+1 cycles.
- The collector accepts one issue per cycle, indefinitely. It applies no backpressure on the issue side.
- With resp_ready held at 1, the sustained throughput is one response per cycle.
- If issue_valid=1 in the same cycle that reset=1, the issue is ignored.

## Configuration
- FPU_RESP_TIMESTAMP_EN defined:
  - A free-running 32-bit cycle counter is added. It is cleared by reset and wraps naturally.
  - The counter value is sampled at issue and carried through the pipeline and FIFO.
  - It is presented on an extra output port, resp_cycle [31:0], which resets to 0.
- FPU_RESP_TIMESTAMP_EN undefined: the resp_cycle port, the counter and the storage bits are all absent. All other behaviour is identical.

## Test plan
- Single op: with LATENCY=4, issue opa=3F800000 and opb=40000000 with op=000 at edge 10, and drive fpu_out=40400000 at edge 14. Required: resp_valid=1 after edge 15, resp_tag=0, resp_out=40400000, resp_flags=00.
- Back-to-back: issue 20 consecutive ops with resp_ready=1. Required: tags 0..19 emerge in order on 20 consecutive cycles, and inflight reads 4 in steady state.
- Backpressure and overflow: with DEPTH=8, hold resp_ready=0 and issue 10 ops. Required: 8 entries are held, drop_err=1, and drop_count=2. Then release resp_ready. Required: tags 0..7 emerge, and the data stays stable across the stall.
- Full with simultaneous pop: keep the FIFO full and pulse resp_ready in the capture cycle. Required: no drop, and the entry count stays at 8.
- Tag wrap: issue 257 ops. Required: the 256th response has tag=255 and the 257th has tag=0.
- Reset mid-flight: assert reset for 1 cycle with 3 ops in flight. Required: no response for those ops, the next issue gets tag=0, and all outputs are 0 on the cycle after reset.
